gastric_pacer: RTL and testbench
================================

Name: gastric_pacer

Overview:
- Closed-loop pacemaker controller at the far end of the stomach ICC chain.
- Monitors the full icc vector emitted by the ring array and detects slow-wave start (ring 0) and arrival (last ring).
- Drives the chain's activate input with a pace pulse when no intrinsic wave starts within the pacing interval.
- Measures end-to-end propagation latency and flags conduction faults.

Parameters:
- NUM_OF_RINGS, 9, rings in the chain.
- ICC_PER_RING, 4, cells per ring.
- RING_PROPAGATION_CYCLES, 20, nominal cycles per ring.
- TOTAL_ICC, ICC_PER_RING*NUM_OF_RINGS, icc vector width (36).
- EXPECTED_LATENCY, NUM_OF_RINGS*RING_PROPAGATION_CYCLES, nominal start-to-arrival cycles (180).
- LATENCY_TOL, 20, extra cycles allowed beyond EXPECTED_LATENCY.
- PACE_INTERVAL, 400, cycles without an intrinsic start before pacing.
- PACE_PULSE_CYCLES, 2, activate pulse width.
- START_TIMEOUT, 8, cycles after pulse end to see the paced start.
- CNT_W, 16, counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  pacer on; low forces IDLE
- clear_faults  in  1  single-cycle clear of sticky fault flags
- icc  in  TOTAL_ICC  ICC activity vector from the ring chain
- activate  out  1  pace pulse to ring 0
- latency_valid  out  1  one-cycle strobe; last_latency updated
- last_latency  out  CNT_W  measured start-to-arrival cycles
- wave_count  out  CNT_W  completed waves, wraps at 2^CNT_W
- paced_wave  out  1  last completed or aborted wave was paced (1) or intrinsic (0)
- block_fault  out  1  sticky: wave failed to reach last ring in time
- capture_fault  out  1  sticky: pace pulse produced no start

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, icc sync/prev registers 0.
- Input stage:
  - icc_q <= icc; icc_p <= icc_q.
  - start_ev = icc_q[0] & ~icc_p[0].
  - end_ev = icc_q[TOTAL_ICC-1] & ~icc_p[TOTAL_ICC-1].
  - Events are seen 1 cycle after the input edge; start and end share the pipeline, so measured latency equals the input edge spacing exactly.
- FSM transitions (registered; they take effect at the edge after the event):
  - IDLE: activate=0, cnt=0. enable=1 -> WAIT_WAVE, cnt=0.
  - WAIT_WAVE: cnt increments.
    - start_ev -> PROPAGATE, cnt=1, paced flag=0.
    - Else if cnt==PACE_INTERVAL-1 -> PACE, cnt=0.
    - If both hold in the same cycle, start_ev wins and no pulse is issued.
  - PACE: activate=1 for exactly PACE_PULSE_CYCLES cycles.
    - Then -> WAIT_START, cnt=0, paced flag=1.
    - start_ev during PACE -> PROPAGATE, cnt=1, paced flag=1. The pulse is truncated and activate=0 from the next cycle.
  - WAIT_START: activate=0, cnt increments.
    - start_ev -> PROPAGATE, cnt=1.
    - cnt==START_TIMEOUT-1 -> capture_fault=1, WAIT_WAVE, cnt=0.
  - PROPAGATE: cnt increments, saturating at 2^CNT_W-1. Further start_ev are ignored.
    - end_ev -> last_latency=cnt, latency_valid=1 for one cycle, wave_count+1, paced_wave=paced flag, WAIT_WAVE, cnt=0.
    - cnt==EXPECTED_LATENCY+LATENCY_TOL without end_ev -> block_fault=1, paced_wave=paced flag, WAIT_WAVE, cnt=0. wave_count and last_latency are unchanged.
- An end_ev outside PROPAGATE is ignored.
- enable low in any state -> IDLE next cycle:
  - activate=0 at once, even mid-pulse; cnt cleared.
  - last_latency, wave_count and fault flags are held.
- Fault flags are cleared only by reset or clear_faults=1. If clear_faults and a fault set coincide in the same cycle, set wins.
- activate is driven from a register, with no combinational path from icc.

Test Plan:
- Intrinsic wave: enable=1; drive icc[0] rise at t=50, icc[35] rise at t=230 -> latency_valid strobe, last_latency=180, wave_count=1, paced_wave=0, activate never high.
- Pacing: enable=1, icc all 0 -> activate high for 2 cycles starting 401 cycles after enable (IDLE exit + 400 wait). Then icc[0] rises 3 cycles after pulse end and icc[35] rises 180 cycles after icc[0] -> last_latency=180, paced_wave=1.
- Capture loss: pace as above, icc[0] never rises -> capture_fault=1 exactly 8 cycles after the pulse ends, FSM back to WAIT_WAVE, next pulse 400 cycles later.
- Conduction block: icc[0] rises, icc[35] silent -> block_fault=1 at cnt=200, wave_count unchanged. Then pulse clear_faults -> block_fault=0.
- Race: icc[0] rise timed so start_ev coincides with cnt==399 -> no activate pulse, PROPAGATE entered.
- Mid-pulse disable: drop enable during the first activate cycle -> activate=0 next cycle, FSM IDLE. reset_n low mid-PROPAGATE -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/gastric_pacer.sv
// ============================================================================
// Module   : gastric_pacer
// Purpose  : Closed-loop slow-wave pacer and conduction monitor for the
//            stomach ICC ring chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gastric_pacer #(
    parameter int NUM_OF_RINGS            = 9,
    parameter int ICC_PER_RING            = 4,
    parameter int RING_PROPAGATION_CYCLES = 20,
    parameter int TOTAL_ICC               = ICC_PER_RING * NUM_OF_RINGS,
    parameter int EXPECTED_LATENCY        = NUM_OF_RINGS * RING_PROPAGATION_CYCLES,
    parameter int LATENCY_TOL             = 20,
    parameter int PACE_INTERVAL           = 400,
    parameter int PACE_PULSE_CYCLES       = 2,
    parameter int START_TIMEOUT           = 8,
    parameter int CNT_W                   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 clear_faults,
    input  logic [TOTAL_ICC-1:0] icc,
    output logic                 activate,
    output logic                 latency_valid,
    output logic [CNT_W-1:0]     last_latency,
    output logic [CNT_W-1:0]     wave_count,
    output logic                 paced_wave,
    output logic                 block_fault,
    output logic                 capture_fault
);

    localparam logic [CNT_W-1:0] c_pace_last   = CNT_W'(PACE_INTERVAL - 1);
    localparam logic [CNT_W-1:0] c_pulse_last  = CNT_W'(PACE_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_start_last  = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_block_limit = CNT_W'(EXPECTED_LATENCY + LATENCY_TOL);
    localparam logic [CNT_W-1:0] c_cnt_max     = '1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_WAVE  = 3'd1,
        S_PACE       = 3'd2,
        S_WAIT_START = 3'd3,
        S_PROPAGATE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TOTAL_ICC-1:0] r_icc_q;
    logic [TOTAL_ICC-1:0] r_icc_p;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_paced;
    logic                 w_paced_nxt;
    logic                 w_act_nxt;
    logic                 w_lv_nxt;
    logic [CNT_W-1:0]     w_lat_nxt;
    logic [CNT_W-1:0]     w_wc_nxt;
    logic                 w_pw_nxt;
    logic                 w_bf_set;
    logic                 w_cf_set;
    logic                 w_start_ev;
    logic                 w_end_ev;
    logic                 w_unused_icc;

    // Start and end edges share one pipeline so latency matches input spacing.
    assign w_start_ev   = r_icc_q[0] & ~r_icc_p[0];
    assign w_end_ev     = r_icc_q[TOTAL_ICC-1] & ~r_icc_p[TOTAL_ICC-1];
    assign w_unused_icc = ^{r_icc_q[TOTAL_ICC-2:1], r_icc_p[TOTAL_ICC-2:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_icc_q       <= '0;
            r_icc_p       <= '0;
            r_cnt         <= '0;
            r_paced       <= 1'b0;
            activate      <= 1'b0;
            latency_valid <= 1'b0;
            last_latency  <= '0;
            wave_count    <= '0;
            paced_wave    <= 1'b0;
            block_fault   <= 1'b0;
            capture_fault <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_icc_q       <= icc;
            r_icc_p       <= r_icc_q;
            r_cnt         <= w_cnt_nxt;
            r_paced       <= w_paced_nxt;
            activate      <= w_act_nxt;
            latency_valid <= w_lv_nxt;
            last_latency  <= w_lat_nxt;
            wave_count    <= w_wc_nxt;
            paced_wave    <= w_pw_nxt;
            // A fault raised in the same cycle as a clear request survives.
            block_fault   <= w_bf_set | (block_fault & ~clear_faults);
            capture_fault <= w_cf_set | (capture_fault & ~clear_faults);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_paced_nxt = r_paced;
        w_act_nxt   = 1'b0;
        w_lv_nxt    = 1'b0;
        w_lat_nxt   = last_latency;
        w_wc_nxt    = wave_count;
        w_pw_nxt    = paced_wave;
        w_bf_set    = 1'b0;
        w_cf_set    = 1'b0;

        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WAIT_WAVE;
                    w_cnt_nxt   = '0;
                end
                S_WAIT_WAVE: begin
                    if (w_start_ev) begin
                        w_state_nxt = S_PROPAGATE;
                        w_cnt_nxt   = CNT_W'(1);
                        w_paced_nxt = 1'b0;
                    end else if (r_cnt == c_pace_last) begin
                        w_state_nxt = S_PACE;
                        w_cnt_nxt   = '0;
                        w_act_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                S_PACE: begin
                    w_paced_nxt = 1'b1;
                    if (w_start_ev) begin
                        w_state_nxt = S_PROPAGATE;
                        w_cnt_nxt   = CNT_W'(1);
                    end else if (r_cnt == c_pulse_last) begin
                        w_state_nxt = S_WAIT_START;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_act_nxt   = 1'b1;
                    end
                end
                S_WAIT_START: begin
                    if (w_start_ev) begin
                        w_state_nxt = S_PROPAGATE;
                        w_cnt_nxt   = CNT_W'(1);
                    end else if (r_cnt == c_start_last) begin
                        w_state_nxt = S_WAIT_WAVE;
                        w_cnt_nxt   = '0;
                        w_cf_set    = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                S_PROPAGATE: begin
                    if (w_end_ev) begin
                        w_state_nxt = S_WAIT_WAVE;
                        w_cnt_nxt   = '0;
                        w_lat_nxt   = r_cnt;
                        w_lv_nxt    = 1'b1;
                        w_wc_nxt    = wave_count + 1'b1;
                        w_pw_nxt    = r_paced;
                    end else if (r_cnt == c_block_limit) begin
                        w_state_nxt = S_WAIT_WAVE;
                        w_cnt_nxt   = '0;
                        w_bf_set    = 1'b1;
                        w_pw_nxt    = r_paced;
                    end else if (r_cnt != c_cnt_max) begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gastric_pacer.sv
// ============================================================================
// Module   : tb_gastric_pacer
// Purpose  : Directed vector bench for gastric_pacer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gastric_pacer;

    localparam int TOTAL_ICC = 36;
    localparam int CNT_W     = 16;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 enable;
    logic                 clear_faults;
    logic [TOTAL_ICC-1:0] icc;
    logic                 activate;
    logic                 latency_valid;
    logic [CNT_W-1:0]     last_latency;
    logic [CNT_W-1:0]     wave_count;
    logic                 paced_wave;
    logic                 block_fault;
    logic                 capture_fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gastric_pacer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .clear_faults  (clear_faults),
        .icc           (icc),
        .activate      (activate),
        .latency_valid (latency_valid),
        .last_latency  (last_latency),
        .wave_count    (wave_count),
        .paced_wave    (paced_wave),
        .block_fault   (block_fault),
        .capture_fault (capture_fault)
    );

    typedef struct {
        int          n;
        logic        en;
        logic        clr;
        logic        s0;
        logic        s35;
        logic        act;
        logic        lv;
        logic [15:0] lat;
        logic [15:0] wc;
        logic        pw;
        logic        bf;
        logic        cf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int n, logic en, logic clr, logic s0, logic s35,
                                logic act, logic lv, int lat, int wc,
                                logic pw, logic bf, logic cf);
        vec_t v;
        v.n = n; v.en = en; v.clr = clr; v.s0 = s0; v.s35 = s35;
        v.act = act; v.lv = lv; v.lat = 16'(lat); v.wc = 16'(wc);
        v.pw = pw; v.bf = bf; v.cf = cf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, "_activate"},      32'(activate),      32'(v.act));
        chk({tag, "_latency_valid"}, 32'(latency_valid), 32'(v.lv));
        chk({tag, "_last_latency"},  32'(last_latency),  32'(v.lat));
        chk({tag, "_wave_count"},    32'(wave_count),    32'(v.wc));
        chk({tag, "_paced_wave"},    32'(paced_wave),    32'(v.pw));
        chk({tag, "_block_fault"},   32'(block_fault),   32'(v.bf));
        chk({tag, "_capture_fault"}, 32'(capture_fault), 32'(v.cf));
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        enable       = 1'b0;
        clear_faults = 1'b0;
        icc          = '0;
        step(2);
        reset_n      = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Columns: cycles, en, clr, icc0, icc35 | act, lv, lat, wc, pw, bf, cf
        tbl.push_back(mk(  1, 1, 0, 0, 0,  0, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(  1, 1, 0, 1, 0,  0, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(179, 1, 0, 1, 0,  0, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(  1, 1, 0, 1, 1,  0, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(  1, 1, 0, 1, 1,  0, 1, 180, 1, 0, 0, 0));
        tbl.push_back(mk(  1, 1, 0, 0, 0,  0, 0, 180, 1, 0, 0, 0));
        tbl.push_back(mk(398, 1, 0, 0, 0,  0, 0, 180, 1, 0, 0, 0));
        tbl.push_back(mk(  1, 1, 0, 0, 0,  1, 0, 180, 1, 0, 0, 0));
        tbl.push_back(mk(  1, 1, 0, 0, 0,  1, 0, 180, 1, 0, 0, 0));
        tbl.push_back(mk(  1, 1, 0, 0, 0,  0, 0, 180, 1, 0, 0, 0));
        tbl.push_back(mk(  2, 1, 0, 0, 0,  0, 0, 180, 1, 0, 0, 0));
        tbl.push_back(mk(  1, 1, 0, 1, 0,  0, 0, 180, 1, 0, 0, 0));
        tbl.push_back(mk(149, 1, 0, 1, 0,  0, 0, 180, 1, 0, 0, 0));
        tbl.push_back(mk(  1, 1, 0, 1, 1,  0, 0, 180, 1, 0, 0, 0));
        tbl.push_back(mk(  1, 1, 0, 1, 1,  0, 1, 150, 2, 1, 0, 0));
        tbl.push_back(mk(  1, 1, 0, 0, 0,  0, 0, 150, 2, 1, 0, 0));
        tbl.push_back(mk(399, 1, 0, 0, 0,  1, 0, 150, 2, 1, 0, 0));
        tbl.push_back(mk(  2, 1, 0, 0, 0,  0, 0, 150, 2, 1, 0, 0));
        tbl.push_back(mk(  7, 1, 0, 0, 0,  0, 0, 150, 2, 1, 0, 0));
        tbl.push_back(mk(  1, 1, 0, 0, 0,  0, 0, 150, 2, 1, 0, 1));
        tbl.push_back(mk(399, 1, 0, 0, 0,  0, 0, 150, 2, 1, 0, 1));
        tbl.push_back(mk(  1, 1, 0, 0, 0,  1, 0, 150, 2, 1, 0, 1));
        tbl.push_back(mk(  1, 0, 0, 0, 0,  0, 0, 150, 2, 1, 0, 1));
        tbl.push_back(mk(  1, 0, 1, 0, 0,  0, 0, 150, 2, 1, 0, 0));
        tbl.push_back(mk(  5, 0, 0, 0, 0,  0, 0, 150, 2, 1, 0, 0));

        do_reset();
        chk_all("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Intrinsic wave, paced wave, capture loss, mid-pulse disable, clear.
        foreach (tbl[i]) begin
            enable       = tbl[i].en;
            clear_faults = tbl[i].clr;
            icc          = '0;
            icc[0]       = tbl[i].s0;
            icc[TOTAL_ICC-1] = tbl[i].s35;
            step(tbl[i].n);
            chk_all($sformatf("v%0d", i), tbl[i]);
        end

        // Start event coincides with the last wait cycle: no pulse, wave measured.
        do_reset();
        enable = 1'b1;
        step(1);
        step(398);
        icc[0] = 1'b1;
        step(1);
        chk("race_act_e399", 32'(activate), 32'd0);
        step(1);
        chk("race_act_e400", 32'(activate), 32'd0);
        step(1);
        chk("race_act_e401", 32'(activate), 32'd0);
        step(57);
        icc[TOTAL_ICC-1] = 1'b1;
        step(2);
        chk("race_lv",  32'(latency_valid), 32'd1);
        chk("race_lat", 32'(last_latency),  32'd60);
        chk("race_wc",  32'(wave_count),    32'd1);
        chk("race_pw",  32'(paced_wave),    32'd0);

        // Asynchronous reset in the middle of a propagating wave.
        icc = '0;
        step(2);
        icc[0] = 1'b1;
        step(5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_lat",  32'(last_latency),  32'd0);
        chk("arst_wc",   32'(wave_count),    32'd0);
        chk("arst_act",  32'(activate),      32'd0);
        chk("arst_lv",   32'(latency_valid), 32'd0);
        step(1);
        reset_n = 1'b1;

        // Conduction block, clear, and a stray end edge outside a wave.
        do_reset();
        enable = 1'b1;
        step(1);
        icc[0] = 1'b1;
        step(1);
        step(200);
        chk("blk_bf_e201", 32'(block_fault), 32'd0);
        step(1);
        chk("blk_bf_e202", 32'(block_fault), 32'd1);
        chk("blk_wc",      32'(wave_count),  32'd0);
        chk("blk_lat",     32'(last_latency), 32'd0);
        chk("blk_lv",      32'(latency_valid), 32'd0);
        clear_faults = 1'b1;
        step(1);
        clear_faults = 1'b0;
        chk("blk_clear", 32'(block_fault), 32'd0);
        icc[TOTAL_ICC-1] = 1'b1;
        step(1);
        chk("stray_lv1", 32'(latency_valid), 32'd0);
        step(1);
        chk("stray_lv2", 32'(latency_valid), 32'd0);
        chk("stray_wc",  32'(wave_count),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
